clock_sequencer: RTL and testbench

//   Synthesizable run/halt/single-step controller for the CPU clock domain.

---
 rtl/clock_sequencer_if.sv | 41 ++++
 rtl/clock_sequencer.sv | 135 +++++++++++++
 tb/tb_clock_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/clock_sequencer_if.sv
// Control/status bundle between a clock_sequencer and whatever drives it.
// The master side drives the request levels and the burst/divide settings;
// the slave side (the sequencer) returns the CE pulse and status.
interface clock_sequencer_if #(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned CNT_W = 16
);
    logic             run_req;
    logic             step_req;
    logic             halt_req;
    logic [CNT_W-1:0] step_count;
    logic [DIV_W-1:0] div;
    logic             cpu_ce;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    modport master (
        output run_req,
        output step_req,
        output halt_req,
        output step_count,
        output div,
        input  cpu_ce,
        input  busy,
        input  done,
        input  state
    );

    modport slave (
        input  run_req,
        input  step_req,
        input  halt_req,
        input  step_count,
        input  div,
        output cpu_ce,
        output busy,
        output done,
        output state
    );
endinterface

// File: rtl/clock_sequencer.sv
// Run/halt/single-step controller producing a registered clock-enable pulse
// train for the CPU domain with a programmable divide ratio (period div+1).
// Modes: continuous RUN, N-cycle STEP burst, halt on request.
// Optional feature: define CLK_SEQ_CECNT_EN to add a free-running 32-bit
// ce_count output that counts every cpu_ce pulse (cleared only by rst).
module clock_sequencer #(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
`ifdef CLK_SEQ_CECNT_EN
    clock_sequencer_if.slave   bus,
    output logic [31:0]        ce_count
`else
    clock_sequencer_if.slave   bus
`endif
);

    localparam logic [1:0] StIdle = 2'b00;
    localparam logic [1:0] StRun  = 2'b01;
    localparam logic [1:0] StStep = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             cpu_ce_q;
    logic             fin_q, fin_d;
    logic             done_q;
    logic             active;
    logic             ce_tick;

    // The unused encoding 2'b11 behaves as IDLE everywhere.
    assign active  = (state_q == StRun) || (state_q == StStep);

    // ce_tick marks the cycle whose registered image is the cpu_ce pulse.
    assign ce_tick = active && (div_cnt_q == div_q);

    // Next-state logic: mode transitions, divider counter and burst counter.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        div_cnt_d   = div_cnt_q;
        remaining_d = remaining_q;
        fin_d       = 1'b0;
        case (state_q)
            StRun: begin
                if (bus.halt_req) begin
                    state_d = StIdle;
                    fin_d   = 1'b1;
                end else if (ce_tick) begin
                    div_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            StStep: begin
                // Halt and the last CE on the same edge collapse into one exit.
                if (bus.halt_req || (ce_tick && (remaining_q == CNT_W'(1)))) begin
                    state_d = StIdle;
                    fin_d   = 1'b1;
                    if (ce_tick) begin
                        remaining_d = remaining_q - CNT_W'(1);
                    end
                end else if (ce_tick) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    div_cnt_d   = '0;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                if (bus.halt_req) begin
                    state_d = StIdle;
                end else if (bus.step_req) begin
                    state_d     = StStep;
                    div_d       = bus.div;
                    div_cnt_d   = '0;
                    remaining_d = (bus.step_count == '0) ? CNT_W'(1) : bus.step_count;
                end else if (bus.run_req) begin
                    state_d   = StRun;
                    div_d     = bus.div;
                    div_cnt_d = '0;
                end
            end
        endcase
    end

    // State registers; rst forces IDLE and suppresses any pending done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            div_q       <= '0;
            div_cnt_q   <= '0;
            remaining_q <= '0;
            cpu_ce_q    <= 1'b0;
            fin_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            div_cnt_q   <= div_cnt_d;
            remaining_q <= remaining_d;
            cpu_ce_q    <= ce_tick;
            fin_q       <= fin_d;
            // done trails the exit by one cycle so it never overlaps the
            // busy cycle of the same transition.
            done_q      <= fin_q;
        end
    end

`ifdef CLK_SEQ_CECNT_EN
    logic [31:0] ce_count_q;

    // Counts on the same edge that raises cpu_ce, so the value includes
    // the pulse currently on the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            ce_count_q <= '0;
        end else if (ce_tick) begin
            ce_count_q <= ce_count_q + 32'd1;
        end
    end

    assign ce_count = ce_count_q;
`endif

    assign bus.cpu_ce = cpu_ce_q;
    assign bus.busy   = active;
    assign bus.done   = done_q;
    assign bus.state  = state_q;

endmodule

// File: tb/tb_clock_sequencer.sv
// Self-checking bench for clock_sequencer: a directed vector table, a few
// hand-written multi-cycle sequences and randomized traffic, all compared
// against a mode/entry-time reference model.
module tb_clock_sequencer;

    logic clk;
    logic rst;
`ifdef CLK_SEQ_CECNT_EN
    logic [31:0] ce_count;
`endif

    clock_sequencer_if #(.DIV_W(8), .CNT_W(16)) bus ();

    clock_sequencer #(.DIV_W(8), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef CLK_SEQ_CECNT_EN
        .bus      (bus),
        .ce_count (ce_count)
`else
        .bus      (bus)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a mode, the edge at which it was entered, the latched
    // divide ratio and the steps still owed. CE times follow from arithmetic
    // on the entry edge rather than from a divider counter.
    int t        = 0;
    int m_mode   = 0;   // 0 idle, 1 run, 2 step
    int m_entry  = 0;
    int m_div    = 0;
    int m_rem    = 0;
    int m_pend   = 0;
    int m_total  = 0;
    int e_ce, e_busy, e_done, e_state;

    task automatic model_edge(input int r, input int ru, input int s, input int h,
                              input int sc, input int dv);
        t++;
        if (r != 0) begin
            m_mode = 0; m_pend = 0; m_total = 0;
            e_ce = 0; e_done = 0; e_busy = 0; e_state = 0;
            return;
        end
        e_done = m_pend;
        m_pend = 0;
        e_ce   = (m_mode != 0 && ((t - m_entry) % (m_div + 1)) == 0) ? 1 : 0;
        if (e_ce != 0) m_total++;
        if (m_mode == 0) begin
            if (h == 0 && s != 0) begin
                m_mode = 2; m_entry = t; m_div = dv; m_rem = (sc == 0) ? 1 : sc;
            end else if (h == 0 && ru != 0) begin
                m_mode = 1; m_entry = t; m_div = dv;
            end
        end else if (m_mode == 1) begin
            if (h != 0) begin
                m_mode = 0; m_pend = 1;
            end
        end else begin
            if (h != 0 || (e_ce != 0 && m_rem == 1)) begin
                m_mode = 0; m_pend = 1;
            end else if (e_ce != 0) begin
                m_rem--;
            end
        end
        e_busy  = (m_mode != 0) ? 1 : 0;
        e_state = m_mode;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at t=%0d: got %0d expected %0d", name, t, act, exp);
    endtask

    // Drive one cycle of inputs, clock it, advance the model, sample #1 later.
    task automatic apply(input int r, input int ru, input int s, input int h,
                         input int sc, input int dv);
        rst           = r[0];
        bus.run_req   = ru[0];
        bus.step_req  = s[0];
        bus.halt_req  = h[0];
        bus.step_count = sc[15:0];
        bus.div       = dv[7:0];
        @(posedge clk);
        model_edge(r, ru, s, h, sc, dv);
        #1;
    endtask

    task automatic check_model();
        check("cpu_ce", int'(bus.cpu_ce), e_ce);
        check("busy",   int'(bus.busy),   e_busy);
        check("done",   int'(bus.done),   e_done);
        check("state",  int'(bus.state),  e_state);
`ifdef CLK_SEQ_CECNT_EN
        check("ce_count", int'(ce_count), m_total);
`endif
    endtask

    typedef struct {
        int rst, run, step, halt, sc, dv;
        int ce, busy, done, st;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int ce_seen, done_seen, first_ce;

        //          rst run stp hlt sc dv   ce bsy dn st
        vecs[0]  = '{1, 0, 0, 0, 0, 0,   0, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 0, 0,   0, 0, 0, 0};
        vecs[2]  = '{0, 0, 1, 0, 4, 1,   0, 1, 0, 2};
        vecs[3]  = '{0, 0, 1, 0, 9, 3,   0, 1, 0, 2};
        vecs[4]  = '{0, 0, 0, 0, 4, 1,   1, 1, 0, 2};
        vecs[5]  = '{0, 1, 0, 0, 4, 1,   0, 1, 0, 2};
        vecs[6]  = '{0, 0, 0, 0, 4, 1,   1, 1, 0, 2};
        vecs[7]  = '{0, 0, 0, 0, 4, 1,   0, 1, 0, 2};
        vecs[8]  = '{0, 0, 0, 0, 4, 1,   1, 1, 0, 2};
        vecs[9]  = '{0, 0, 0, 0, 4, 1,   0, 1, 0, 2};
        vecs[10] = '{0, 0, 0, 0, 4, 1,   1, 0, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 4, 1,   0, 0, 1, 0};
        vecs[12] = '{0, 0, 0, 1, 4, 1,   0, 0, 0, 0};
        vecs[13] = '{0, 0, 1, 0, 0, 0,   0, 1, 0, 2};
        vecs[14] = '{0, 0, 0, 0, 0, 0,   1, 0, 0, 0};
        vecs[15] = '{0, 0, 0, 0, 0, 0,   0, 0, 1, 0};
        vecs[16] = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0};

        // Directed table: reset, a 4-step burst at div=1, step_count=0.
        for (int i = 0; i < 17; i++) begin
            apply(vecs[i].rst, vecs[i].run, vecs[i].step, vecs[i].halt,
                  vecs[i].sc, vecs[i].dv);
            check($sformatf("tbl%0d.cpu_ce", i), int'(bus.cpu_ce), vecs[i].ce);
            check($sformatf("tbl%0d.busy", i),   int'(bus.busy),   vecs[i].busy);
            check($sformatf("tbl%0d.done", i),   int'(bus.done),   vecs[i].done);
            check($sformatf("tbl%0d.state", i),  int'(bus.state),  vecs[i].st);
        end

        // RUN at div=0, halt sampled 10 edges later: 10 CEs, then done.
        apply(0, 1, 0, 0, 0, 0);
        check_model();
        ce_seen = 0;
        for (int i = 1; i <= 10; i++) begin
            apply(0, 0, 0, (i == 10) ? 1 : 0, 0, 7);
            check_model();
            ce_seen += int'(bus.cpu_ce);
        end
        check("run_div0_ce_total", ce_seen, 10);
        apply(0, 0, 0, 0, 0, 0);
        check_model();
        check("run_div0_done", int'(bus.done), 1);
        check("run_div0_state", int'(bus.state), 0);

        // RUN at div=2: first CE 3 cycles after the request, then every 3rd.
        apply(0, 1, 0, 0, 0, 2);
        check_model();
        first_ce = -1;
        ce_seen  = 0;
        for (int i = 1; i <= 9; i++) begin
            apply(0, 0, 0, 0, 0, 0);
            check_model();
            if (bus.cpu_ce && first_ce < 0) first_ce = i;
            ce_seen += int'(bus.cpu_ce);
        end
        check("run_div2_first_ce", first_ce, 3);
        check("run_div2_ce_total", ce_seen, 3);
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, (i == 0) ? 1 : 0, 0, 0);
            check_model();
        end

        // STEP of 5 at div=1, halted right after the 2nd CE is seen.
        apply(0, 0, 1, 0, 5, 1);
        check_model();
        ce_seen   = 0;
        done_seen = 0;
        for (int i = 0; i < 20 && ce_seen < 2; i++) begin
            apply(0, 0, 0, 0, 5, 1);
            check_model();
            ce_seen += int'(bus.cpu_ce);
        end
        for (int i = 0; i < 8; i++) begin
            apply(0, 0, 0, (i == 0) ? 1 : 0, 5, 1);
            check_model();
            ce_seen   += int'(bus.cpu_ce);
            done_seen += int'(bus.done);
        end
        check("abort_ce_total", ce_seen, 2);
        check("abort_done_count", done_seen, 1);

        // rst in the middle of a long STEP burst: IDLE at once, no done.
        apply(0, 0, 1, 0, 10, 1);
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 10, 1);
        check_model();
        apply(1, 0, 0, 0, 10, 1);
        check_model();
        check("rst_mid_busy", int'(bus.busy), 0);
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 0, 0, 0);
            check_model();
            done_seen += int'(bus.done);
        end
        check("rst_mid_no_done", done_seen, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(0, 99) < 2) ? 1 : 0,
                  ($urandom_range(0, 7) == 0) ? 1 : 0,
                  ($urandom_range(0, 7) == 0) ? 1 : 0,
                  ($urandom_range(0, 15) == 0) ? 1 : 0,
                  int'($urandom_range(0, 6)),
                  int'($urandom_range(0, 3)));
            check_model();
        end

`ifdef CLK_SEQ_CECNT_EN
        check("ce_count_final", int'(ce_count), m_total);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
